// File: rtl/myproject_sdiv_36s_11ns_33_seq_pkg.sv
// Shared types and constants for the sequential signed/unsigned divider.
// Widths, FSM states and quotient saturation limits.
package myproject_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DIVIDEND_W = 36;
    localparam int DIVISOR_W  = 11;
    localparam int QUOT_W     = 33;
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    localparam logic [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    localparam logic [DIVIDEND_W-1:0] QMAX_MAG = DIVIDEND_W'(QMAX);
    localparam logic [DIVIDEND_W-1:0] QMIN_MAG = DIVIDEND_W'(QMIN);

    // -2^(W-1) maps to 2^(W-1), which still fits unsigned
    function automatic logic [DIVIDEND_W-1:0] magnitude(
        input logic [DIVIDEND_W-1:0] v
    );
        return v[DIVIDEND_W-1] ? DIVIDEND_W'(0) - v : v;
    endfunction

endpackage

// File: rtl/myproject_sdiv_36s_11ns_33_seq_if.sv
// Operand/result handshake bundle of the divider.
// slave is the divider side, master the producer/consumer side.
interface myproject_sdiv_36s_11ns_33_seq_if;
    import myproject_div_pkg::*;

    logic                  in_vld;
    logic                  in_rdy;
    logic [DIVIDEND_W-1:0] din0;
    logic [DIVISOR_W-1:0]  din1;
    logic                  out_vld;
    logic                  out_rdy;
    logic [QUOT_W-1:0]     quot;
    logic [REM_W-1:0]      rem;
    logic                  ovf;
    logic                  dbz;

    modport slave (
        input  in_vld, din0, din1, out_rdy,
        output in_rdy, out_vld, quot, rem, ovf, dbz
    );

    modport master (
        output in_vld, din0, din1, out_rdy,
        input  in_rdy, out_vld, quot, rem, ovf, dbz
    );

endinterface

// File: rtl/myproject_div_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if non-negative.
module myproject_div_step
    import myproject_div_pkg::*;
(
    input  logic [REM_W-1:0]     rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] dvs,
    output logic [REM_W-1:0]     rem_out,
    output logic                 qbit
);

    logic [REM_W:0] shifted;
    logic [REM_W:0] trial;

    assign shifted = {rem_in, bit_in};
    assign trial   = shifted - {2'b00, dvs};
    assign qbit    = ~trial[REM_W];
    assign rem_out = qbit ? trial[REM_W-1:0] : shifted[REM_W-1:0];

endmodule

// File: rtl/myproject_sdiv_36s_11ns_33_seq.sv
// Sequential 36s / 11u divider, one quotient bit per cycle, with
// quotient saturation and divide-by-zero reporting.
module myproject_sdiv_36s_11ns_33_seq
    import myproject_div_pkg::*;
(
    input logic ap_clk,
    input logic ap_rst_n,
    myproject_sdiv_36s_11ns_33_seq_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] mag;
    logic [DIVIDEND_W-1:0] qacc;
    logic [REM_W-1:0]      prem;
    logic [DIVISOR_W-1:0]  dvs;
    logic                  neg;
    logic                  zdiv;

    logic [QUOT_W-1:0]     quot_q;
    logic [REM_W-1:0]      rem_q;
    logic                  ovf_q;
    logic                  dbz_q;

    logic [REM_W-1:0]      prem_nxt;
    logic                  qbit;
    logic                  accept;
    logic                  fin;
    logic                  take;

    logic [QUOT_W-1:0]     q_fin;
    logic [REM_W-1:0]      r_fin;
    logic                  o_fin;

    assign accept = (state == IDLE) && bus.in_vld;
    assign fin    = (state == CALC) &&
                    (zdiv || cnt == CNT_W'(DIVIDEND_W));
    assign take   = (state == DONE) && bus.out_rdy;

    myproject_div_step u_step (
        .rem_in  (prem),
        .bit_in  (mag[DIVIDEND_W-1]),
        .dvs     (dvs),
        .rem_out (prem_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (fin) state_nxt = DONE;
            DONE: if (bus.out_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign fix and saturation of the finished magnitude quotient
    always_comb begin
        q_fin = '0;
        r_fin = '0;
        o_fin = 1'b0;
        if (zdiv) begin
            q_fin = neg ? QMIN : QMAX;
        end else if (!neg) begin
            r_fin = prem;
            if (qacc > QMAX_MAG) begin
                q_fin = QMAX;
                o_fin = 1'b1;
            end else begin
                q_fin = qacc[QUOT_W-1:0];
            end
        end else begin
            r_fin = REM_W'(0) - prem;
            if (qacc > QMIN_MAG) begin
                q_fin = QMIN;
                o_fin = 1'b1;
            end else begin
                q_fin = QUOT_W'(0) - qacc[QUOT_W-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt    <= '0;
            mag    <= '0;
            qacc   <= '0;
            prem   <= '0;
            dvs    <= '0;
            neg    <= 1'b0;
            zdiv   <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            mag  <= magnitude(bus.din0);
            qacc <= '0;
            prem <= '0;
            dvs  <= bus.din1;
            neg  <= bus.din0[DIVIDEND_W-1];
            zdiv <= (bus.din1 == '0);
        end else if (fin) begin
            quot_q <= q_fin;
            rem_q  <= r_fin;
            ovf_q  <= o_fin;
            dbz_q  <= zdiv;
        end else if (state == CALC) begin
            prem <= prem_nxt;
            qacc <= {qacc[DIVIDEND_W-2:0], qbit};
            mag  <= {mag[DIVIDEND_W-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
        end else if (take) begin
            cnt    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end
    end

    assign bus.in_rdy  = (state == IDLE);
    assign bus.out_vld = (state == DONE);
    assign bus.quot    = quot_q;
    assign bus.rem     = rem_q;
    assign bus.ovf     = ovf_q;
    assign bus.dbz     = dbz_q;

endmodule
